lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data and address width (only 32 supported).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port data_req_i  input  1  decoder requests memory access.
REQ-005 SHALL have port data_we_i  input  1  1 store, 0 load.
REQ-006 SHALL have port data_type_i  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 SHALL have port data_sign_ext_i  input  1  sign-extend load data when 1, else zero-extend.
REQ-008 SHALL have port addr_i  input  32  effective byte address (ALU result).
REQ-009 SHALL have port wdata_i  input  32  store data (rs2 value).
REQ-010 SHALL have port busy_o  output  1  LSU occupied; core stalls.
REQ-011 SHALL have port valid_o  output  1  one-cycle pulse: access completed OK.
REQ-012 SHALL have port rdata_o  output  32  extended load result, qualified by valid_o.
REQ-013 SHALL have port err_o  output  1  one-cycle pulse: misaligned, illegal type or bus error.
REQ-014 SHALL have port mem_req_o  output  1  memory request, held until granted.
REQ-015 SHALL have port mem_gnt_i  input  1  memory accepts request.
REQ-016 SHALL have port mem_addr_o  output  32  word-aligned address, bits [1:0] = 00.
REQ-017 SHALL have ports mem_we_o (output 1), mem_be_o (output 4) and mem_wdata_o (output 32): write enable, byte enables, lane-replicated write data.
REQ-018 SHALL have ports mem_rvalid_i (input 1), mem_rdata_i (input 32) and mem_err_i (input 1): response valid, read word, bus error qualified by rvalid.

Function
REQ-019 SHALL implement FSM IDLE -> REQ -> RESP -> IDLE.
REQ-020 In IDLE with data_req_i=1, SHALL register addr, we, type, sign_ext and wdata, then go to REQ; data_req_i SHALL be ignored outside IDLE.
REQ-021 Misalignment SHALL be: type word with addr_i[1:0]!=0, type half with addr_i[0]=1, or type 11. A misaligned request SHALL stay in IDLE, pulse err_o the next cycle and issue no mem_req_o.
REQ-022 In REQ, mem_req_o=1 with address, we, be and wdata stable until mem_gnt_i=1; then go to RESP.
REQ-023 In RESP, on mem_rvalid_i=1: go to IDLE; next cycle pulse valid_o if mem_err_i=0, else pulse err_o.
REQ-024 Minimum latency SHALL be 3 cycles from data_req_i to valid_o (gnt in first REQ cycle, rvalid in first RESP cycle).
REQ-025 busy_o SHALL be 1 in REQ and RESP, and in IDLE on a cycle where a valid request is accepted.
REQ-026 Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-027 Write data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged.
REQ-028 Load data SHALL be mem_rdata_i >> (8*addr[1:0]); the low 8 or 16 bits SHALL be sign- or zero-extended per type and sign_ext; word passes unchanged.
REQ-029 For stores, rdata_o SHALL be 0 and valid_o SHALL still pulse on completion.
REQ-030 rdata_o SHALL be registered and hold its value until the next completion.
REQ-031 mem_rvalid_i outside RESP SHALL be ignored.
REQ-032 mem_gnt_i and mem_rvalid_i in the same cycle in REQ SHALL be treated as grant only; the response is still awaited in RESP.

Reset
REQ-033 On rst_n=0, the FSM SHALL go to IDLE immediately (asynchronously), aborting any in-flight access.
REQ-034 During reset, busy_o, valid_o, err_o, mem_req_o, mem_we_o SHALL be 0, and mem_be_o, mem_addr_o, mem_wdata_o, rdata_o SHALL be 0.

Structure
REQ-035 The FSM state enum lsu_state_e and the constants DATA_TYPE_BYTE, DATA_TYPE_HALF, DATA_TYPE_WORD SHALL live in toothless_pkg, shared with the decoder.
REQ-036 Load extraction and extension SHALL be in combinational sub-module lsu_rdata_align, instantiated once.

Verification
REQ-037 Word load at addr 0x100, gnt immediate, rvalid next cycle with rdata 0xDEADBEEF -> mem_addr_o 0x100, be 1111, valid_o at cycle 3, rdata_o 0xDEADBEEF.
REQ-038 Signed byte load at addr 0x103, rdata 0x80FF1234 -> be 1000, rdata_o 0xFFFFFF80; same access unsigned -> 0x00000080.
REQ-039 Half store at addr 0x202, wdata 0x0000ABCD -> be 1100, mem_wdata_o 0xABCDABCD, mem_we_o 1, valid_o pulses with rdata_o 0.
REQ-040 Word load at 0x101 and type 11 at 0x100 -> err_o pulses, mem_req_o never asserted, busy_o low afterwards.
REQ-041 gnt withheld 5 cycles, then rvalid with mem_err_i=1 -> mem_req_o and mem_addr_o stable throughout, err_o pulses, valid_o stays 0.
REQ-042 rst_n dropped while in RESP -> outputs 0 immediately; a late rvalid after reset is ignored.

Source files
------------

// File: rtl/toothless_pkg.sv
// Shared LSU/decoder types: FSM states, access sizes
// and lane helpers for byte enables and store data.
package toothless_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_RESP = 2'b10
  } lsu_state_e;

  localparam logic [1:0] DATA_TYPE_BYTE = 2'b00;
  localparam logic [1:0] DATA_TYPE_HALF = 2'b01;
  localparam logic [1:0] DATA_TYPE_WORD = 2'b10;

  function automatic logic misaligned(
    input logic [1:0] t,
    input logic [1:0] a
  );
    return ((t == DATA_TYPE_WORD) && (a != 2'b00))
         | ((t == DATA_TYPE_HALF) && a[0])
         | (t == 2'b11);
  endfunction

  function automatic logic [3:0] be_gen(
    input logic [1:0] t,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (1'b1)
      (t == DATA_TYPE_BYTE): be = 4'b0001 << a;
      (t == DATA_TYPE_HALF): be = 4'b0011 << a;
      default:               be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_gen(
    input logic [1:0]  t,
    input logic [31:0] d
  );
    logic [31:0] w;
    w = d;
    unique case (1'b1)
      (t == DATA_TYPE_BYTE): w = {4{d[7:0]}};
      (t == DATA_TYPE_HALF): w = {2{d[15:0]}};
      default:               w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_rdata_align.sv
// Load lane extraction: shift the addressed bytes down,
// then sign- or zero-extend to the full word.
module lsu_rdata_align
  import toothless_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  type_i,
  input  logic        sext_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    rdata_o = shifted;
    unique case (1'b1)
      (type_i == DATA_TYPE_BYTE):
        rdata_o = {{24{sext_i & shifted[7]}},
                   shifted[7:0]};
      (type_i == DATA_TYPE_HALF):
        rdata_o = {{16{sext_i & shifted[15]}},
                   shifted[15:0]};
      default:
        rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding access over a
// req/gnt + rvalid bus, with alignment and lane steering.
module lsu
  import toothless_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [1:0]            data_type_i,
  input  logic                  data_sign_ext_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [31:0]           mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i
);

  lsu_state_e  state_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [1:0]  off_q;
  logic [1:0]  type_q;
  logic        sext_q;
  logic        valid_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;
  logic        mis;
  logic        accept;

  assign mis    = misaligned(data_type_i, addr_i[1:0]);
  assign accept = (state_q == LSU_IDLE)
                & data_req_i & ~mis;
  // rst_n gate keeps the combinational accept path quiet in reset
  assign busy_o = rst_n
                & ((state_q != LSU_IDLE) | accept);

  lsu_rdata_align u_align (
    .off_i   (off_q),
    .type_i  (type_q),
    .sext_i  (sext_q),
    .rdata_i (mem_rdata_i),
    .rdata_o (rdata_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LSU_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      off_q       <= 2'b00;
      type_q      <= DATA_TYPE_BYTE;
      sext_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        LSU_IDLE: begin
          if (data_req_i && mis) begin
            err_q <= 1'b1;
          end else if (data_req_i) begin
            state_q     <= LSU_REQ;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= {addr_i[31:2], 2'b00};
            mem_we_q    <= data_we_i;
            mem_be_q    <= be_gen(data_type_i,
                                  addr_i[1:0]);
            mem_wdata_q <= wdata_gen(data_type_i,
                                     wdata_i);
            off_q       <= addr_i[1:0];
            type_q      <= data_type_i;
            sext_q      <= data_sign_ext_i;
          end
        end
        LSU_REQ: begin
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= LSU_RESP;
          end
        end
        LSU_RESP: begin
          if (mem_rvalid_i) begin
            state_q <= LSU_IDLE;
            if (mem_err_i) begin
              err_q <= 1'b1;
            end else begin
              valid_q <= 1'b1;
              rdata_q <= mem_we_q ? '0 : rdata_d;
            end
          end
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign valid_o     = valid_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table of single
// accesses plus hand-written stall, overlap and reset cases.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [1:0]  data_type_i = 2'b00;
  logic        data_sign_ext_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_err_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  lsu #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_req_i      (data_req_i),
    .data_we_i       (data_we_i),
    .data_type_i     (data_type_i),
    .data_sign_ext_i (data_sign_ext_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .busy_o          (busy_o),
    .valid_o         (valid_o),
    .rdata_o         (rdata_o),
    .err_o           (err_o),
    .mem_req_o       (mem_req_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_addr_o      (mem_addr_o),
    .mem_we_o        (mem_we_o),
    .mem_be_o        (mem_be_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .mem_err_i       (mem_err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  typ;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic        bad;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    data_req_i      = 1'b1;
    data_we_i       = v.we;
    data_type_i     = v.typ;
    data_sign_ext_i = v.sext;
    addr_i          = v.addr;
    wdata_i         = v.wdata;
    #1;
    chk({v.name, ".busy0"}, 32'(busy_o), 32'(!v.bad));
    step();
    data_req_i = 1'b0;
    if (v.bad) begin
      chk({v.name, ".err"}, 32'(err_o), 32'd1);
      chk({v.name, ".req"}, 32'(mem_req_o), 32'd0);
      chk({v.name, ".busy"}, 32'(busy_o), 32'd0);
      step();
      chk({v.name, ".err1"}, 32'(err_o), 32'd0);
      chk({v.name, ".req1"}, 32'(mem_req_o), 32'd0);
    end else begin
      chk({v.name, ".req"}, 32'(mem_req_o), 32'd1);
      chk({v.name, ".addr"}, mem_addr_o, v.e_addr);
      chk({v.name, ".be"}, 32'(mem_be_o), 32'(v.e_be));
      chk({v.name, ".wd"}, mem_wdata_o, v.e_wdata);
      chk({v.name, ".we"}, 32'(mem_we_o), 32'(v.we));
      mem_gnt_i = 1'b1;
      step();
      mem_gnt_i = 1'b0;
      chk({v.name, ".reqoff"}, 32'(mem_req_o), 32'd0);
      chk({v.name, ".busy"}, 32'(busy_o), 32'd1);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = v.mrdata;
      step();
      mem_rvalid_i = 1'b0;
      chk({v.name, ".valid"}, 32'(valid_o), 32'd1);
      chk({v.name, ".rdata"}, rdata_o, v.e_rdata);
      chk({v.name, ".err"}, 32'(err_o), 32'd0);
      step();
      chk({v.name, ".valid1"}, 32'(valid_o), 32'd0);
      chk({v.name, ".hold"}, rdata_o, v.e_rdata);
    end
  endtask

  initial begin
    vecs[0]  = '{"ldw100", 0, 2'b10, 0, 32'h100, 0,
                 32'hDEADBEEF, 0, 32'h100, 4'hF, 0,
                 32'hDEADBEEF};
    vecs[1]  = '{"lb103s", 0, 2'b00, 1, 32'h103, 0,
                 32'h80FF1234, 0, 32'h100, 4'h8, 0,
                 32'hFFFFFF80};
    vecs[2]  = '{"lb103u", 0, 2'b00, 0, 32'h103, 0,
                 32'h80FF1234, 0, 32'h100, 4'h8, 0,
                 32'h00000080};
    vecs[3]  = '{"sh202", 1, 2'b01, 0, 32'h202,
                 32'h0000ABCD, 32'h55555555, 0, 32'h200,
                 4'hC, 32'hABCDABCD, 0};
    vecs[4]  = '{"sb001", 1, 2'b00, 0, 32'h001,
                 32'h12345678, 0, 0, 32'h0, 4'h2,
                 32'h78787878, 0};
    vecs[5]  = '{"lh302s", 0, 2'b01, 1, 32'h302, 0,
                 32'h80011234, 0, 32'h300, 4'hC, 0,
                 32'hFFFF8001};
    vecs[6]  = '{"lh300u", 0, 2'b01, 0, 32'h300, 0,
                 32'h1234F00D, 0, 32'h300, 4'h3, 0,
                 32'h0000F00D};
    vecs[7]  = '{"lw101", 0, 2'b10, 0, 32'h101, 0,
                 0, 1, 0, 0, 0, 0};
    vecs[8]  = '{"t11", 0, 2'b11, 0, 32'h100, 0,
                 0, 1, 0, 0, 0, 0};
    vecs[9]  = '{"lh203", 0, 2'b01, 0, 32'h203, 0,
                 0, 1, 0, 0, 0, 0};
    vecs[10] = '{"sw404", 1, 2'b10, 0, 32'h404,
                 32'hCAFEF00D, 0, 0, 32'h404, 4'hF,
                 32'hCAFEF00D, 0};

    #2;
    chk("rst.busy", 32'(busy_o), 0);
    chk("rst.req", 32'(mem_req_o), 0);
    chk("rst.valid", 32'(valid_o), 0);
    chk("rst.err", 32'(err_o), 0);
    chk("rst.rdata", rdata_o, 0);
    chk("rst.addr", mem_addr_o, 0);
    chk("rst.be", 32'(mem_be_o), 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // grant stalled 5 cycles, bus error response
    data_req_i = 1'b1; data_we_i = 1'b0;
    data_type_i = 2'b10; addr_i = 32'h500;
    step();
    addr_i = 32'h900;
    for (int i = 0; i < 5; i++) begin
      chk("stall.req", 32'(mem_req_o), 1);
      chk("stall.addr", mem_addr_o, 32'h500);
      step();
    end
    data_req_i = 1'b0;
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_err_i = 1'b1;
    step();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    chk("berr.err", 32'(err_o), 1);
    chk("berr.valid", 32'(valid_o), 0);
    step();
    chk("berr.err1", 32'(err_o), 0);
    chk("berr.busy", 32'(busy_o), 0);

    // rvalid in IDLE ignored; gnt+rvalid together in REQ
    mem_rvalid_i = 1'b1;
    step();
    chk("idle.rv", 32'(valid_o), 0);
    data_req_i = 1'b1; addr_i = 32'h600;
    step();
    data_req_i = 1'b0;
    mem_gnt_i = 1'b1; mem_rdata_i = 32'h11111111;
    step();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    step();
    chk("ovl.valid", 32'(valid_o), 0);
    chk("ovl.busy", 32'(busy_o), 1);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h22222222;
    step();
    mem_rvalid_i = 1'b0;
    chk("ovl.valid2", 32'(valid_o), 1);
    chk("ovl.rdata", rdata_o, 32'h22222222);

    // reset while waiting in RESP
    data_req_i = 1'b1; addr_i = 32'h700;
    step();
    data_req_i = 1'b0; mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar.busy", 32'(busy_o), 0);
    chk("ar.rdata", rdata_o, 0);
    chk("ar.addr", mem_addr_o, 0);
    chk("ar.be", 32'(mem_be_o), 0);
    step();
    rst_n = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h33333333;
    step();
    mem_rvalid_i = 1'b0;
    chk("late.valid", 32'(valid_o), 0);
    chk("late.err", 32'(err_o), 0);
    chk("late.busy", 32'(busy_o), 0);
    chk("late.rdata", rdata_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
